// File: rtl/hv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hv_pkg
// Description : Shared types and elaboration helpers for the hypervector
//               similarity engine.
// Revision    : 1.0 - initial release
// ============================================================================
package hv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } fsm_state;

  typedef enum logic {
    SIM_OVERLAP = 1'b0,
    SIM_HAMMING = 1'b1
  } sim_mode;

  // Chunked processing only works when the vector splits into whole chunks.
  function automatic bit chunk_divides(input int length_vector, input int chunk);
    return (chunk > 0) && ((length_vector % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_similarity_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : hv_similarity_engine_if
// Description : Request/result bundle between requester and similarity engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface hv_similarity_engine_if #(
  parameter int LENGTH_VECTOR  = 1024,
  parameter int LENGTH_COUNTER = $clog2(LENGTH_VECTOR + 1)
);
  logic                      start;
  logic                      mode;
  logic [LENGTH_VECTOR-1:0]  hv_a;
  logic [LENGTH_VECTOR-1:0]  hv_b;
  logic [LENGTH_COUNTER-1:0] threshold;
  logic                      busy;
  logic                      done;
  logic [LENGTH_COUNTER-1:0] counter_out;
  logic                      match;

  modport master (
    output start, mode, hv_a, hv_b, threshold,
    input  busy, done, counter_out, match
  );

  modport slave (
    input  start, mode, hv_a, hv_b, threshold,
    output busy, done, counter_out, match
  );
endinterface
`default_nettype wire

// File: rtl/hv_popcount.sv
`default_nettype none
// ============================================================================
// Module      : hv_popcount
// Description : Combinational adder-tree population count.
// Revision    : 1.0 - initial release
// ============================================================================
module hv_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             i_bits,
  output logic [$clog2(WIDTH+1)-1:0]   o_count
);
  localparam int c_out_w = $clog2(WIDTH + 1);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign o_count = i_bits;
    end else begin : g_split
      localparam int c_lo_w = WIDTH / 2;
      localparam int c_hi_w = WIDTH - c_lo_w;

      logic [$clog2(c_lo_w+1)-1:0] w_lo;
      logic [$clog2(c_hi_w+1)-1:0] w_hi;

      hv_popcount #(.WIDTH(c_lo_w)) u_lo (
        .i_bits  (i_bits[c_lo_w-1:0]),
        .o_count (w_lo)
      );
      hv_popcount #(.WIDTH(c_hi_w)) u_hi (
        .i_bits  (i_bits[WIDTH-1:c_lo_w]),
        .o_count (w_hi)
      );

      assign o_count = c_out_w'(w_lo) + c_out_w'(w_hi);
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/hv_similarity_engine.sv
`default_nettype none
// ============================================================================
// Module      : hv_similarity_engine
// Description : Chunked overlap / Hamming similarity counter for binary
//               hypervectors with threshold-match flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hv_similarity_engine
  import hv_pkg::*;
#(
  parameter int LENGTH_VECTOR = 1024,
  parameter int CHUNK         = 32
) (
  input  logic                   clk,
  input  logic                   arst_in,
  hv_similarity_engine_if.slave  bus
);
  localparam int NUM_CHUNKS     = LENGTH_VECTOR / CHUNK;
  localparam int LENGTH_COUNTER = $clog2(LENGTH_VECTOR + 1);
  localparam int c_pop_w        = $clog2(CHUNK + 1);
  localparam int c_idx_w        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CHUNKS - 1);

  generate
    if (!chunk_divides(LENGTH_VECTOR, CHUNK)) begin : g_chunk_check
      $error("hv_similarity_engine: CHUNK must divide LENGTH_VECTOR");
    end
  endgenerate

  fsm_state                  r_state;
  fsm_state                  w_state_next;
  logic [LENGTH_VECTOR-1:0]  r_hv_a;
  logic [LENGTH_VECTOR-1:0]  r_hv_b;
  sim_mode                   r_mode;
  logic [LENGTH_COUNTER-1:0] r_threshold;
  logic [LENGTH_COUNTER-1:0] r_acc;
  logic [c_idx_w-1:0]        r_idx;
  logic                      r_busy;
  logic                      r_done;
  logic [LENGTH_COUNTER-1:0] r_counter;
  logic                      r_match;
  logic [CHUNK-1:0]          w_chunk;
  logic [c_pop_w-1:0]        w_pop;

  assign w_chunk = (r_mode == SIM_HAMMING) ? (r_hv_a[CHUNK-1:0] ^ r_hv_b[CHUNK-1:0])
                                           : (r_hv_a[CHUNK-1:0] & r_hv_b[CHUNK-1:0]);

  hv_popcount #(.WIDTH(CHUNK)) u_popcount (
    .i_bits  (w_chunk),
    .o_count (w_pop)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = COUNT;
      COUNT:   if (r_idx == c_last_idx) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_hv_a      <= '0;
      r_hv_b      <= '0;
      r_mode      <= SIM_OVERLAP;
      r_threshold <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_counter   <= '0;
      r_match     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_hv_a      <= bus.hv_a;
            r_hv_b      <= bus.hv_b;
            r_mode      <= sim_mode'(bus.mode);
            r_threshold <= bus.threshold;
            r_acc       <= '0;
            r_idx       <= '0;
          end
        end
        COUNT: begin
          r_acc  <= r_acc + LENGTH_COUNTER'(w_pop);
          r_hv_a <= r_hv_a >> CHUNK;
          r_hv_b <= r_hv_b >> CHUNK;
          r_idx  <= r_idx + c_idx_w'(1);
        end
        default: ;
      endcase

      r_busy <= (r_state != IDLE);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_counter <= r_acc;
        r_match   <= (r_acc >= r_threshold);
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.counter_out = r_counter;
  assign bus.match       = r_match;
endmodule
`default_nettype wire

// File: tb/tb_hv_similarity_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_hv_similarity_engine
// Description : Scoreboard bench for hv_similarity_engine (32-bit vectors,
//               8-bit chunks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hv_similarity_engine;
  localparam int c_lv    = 32;
  localparam int c_chunk = 8;

  typedef struct {
    logic [5:0] cnt;
    logic       m;
    int         cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  arst_in = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  exp_t  q[$];
  exp_t  mon_e;

  hv_similarity_engine_if #(.LENGTH_VECTOR(c_lv)) bus ();

  hv_similarity_engine #(.LENGTH_VECTOR(c_lv), .CHUNK(c_chunk)) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && bus.done === 1'b1) begin
      chk("done_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("counter_out", {26'd0, bus.counter_out}, {26'd0, mon_e.cnt});
        chk("match", {31'd0, bus.match}, {31'd0, mon_e.m});
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic md,
                       input logic [5:0] thr);
    bus.hv_a      = a;
    bus.hv_b      = b;
    bus.mode      = md;
    bus.threshold = thr;
    bus.start     = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic md,
                        input logic [5:0] thr, input logic [5:0] exp_cnt, input logic exp_m);
    @(negedge clk);
    issue(a, b, md, thr);
    q.push_back('{exp_cnt, exp_m, cyc + 6});
    @(negedge clk);
    bus.start = 1'b0;
    drain();
  endtask

  initial begin
    int c;
    bus.start = 1'b0; bus.mode = 1'b0; bus.hv_a = '0; bus.hv_b = '0; bus.threshold = '0;

    // Asynchronous reset between clock edges
    #12 arst_in = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_match", {31'd0, bus.match}, 32'd0);
    chk("rst_counter", {26'd0, bus.counter_out}, 32'd0);
    @(negedge clk);
    arst_in = 1'b0;
    mon_en  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
    end

    run_op(32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 6'd8,  6'd8,  1'b1);
    run_op(32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 6'd17, 6'd16, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6'd32, 6'd32, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 6'd0,  6'd0,  1'b1);

    // Operands and start change during COUNT; the captured request must win.
    @(negedge clk);
    c = cyc;
    issue(32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 6'd16);
    q.push_back('{6'd16, 1'b1, c + 6});
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_before_rise", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("busy_during", {31'd0, bus.busy}, 32'd1);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 6'd0);
    @(negedge clk);
    chk("busy_during", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("busy_during", {31'd0, bus.busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_fall", {31'd0, bus.busy}, 32'd0);
    drain();

    // Reset in the second COUNT cycle aborts the operation and loses the old result.
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6'd0);
    q.push_back('{6'd32, 1'b1, cyc + 6});
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 arst_in = 1'b1;
    #1;
    q.delete();
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_counter", {26'd0, bus.counter_out}, 32'd0);
    chk("midrst_match", {31'd0, bus.match}, 32'd0);
    @(negedge clk);
    arst_in = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, bus.done}, 32'd0);
      chk("post_rst_counter", {26'd0, bus.counter_out}, 32'd0);
    end
    run_op(32'h1234_5678, 32'h0000_0000, 1'b1, 6'd13, 6'd13, 1'b1);

    // start held high: second request accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    c = cyc;
    issue(32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 6'd20);
    q.push_back('{6'd16, 1'b0, c + 6});
    q.push_back('{6'd16, 1'b0, c + 12});
    repeat (7) @(negedge clk);
    bus.start = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
